// File: rtl/apb_regfile_completer.sv
// ============================================================================
// Module   : apb_regfile_completer
// Brief    : APB4 completer for a bank of word-wide registers with wait states,
//            PSLVERR signalling, byte strobes, read-only masking and write pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_regfile_completer #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           PCLK,
    input  logic                           reset,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] HwIn,
    output logic [NUM_REGS*DATA_WIDTH-1:0] RegOut,
    output logic [NUM_REGS-1:0]            WrPulse
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_LSB    = (c_STRB_W > 1) ? $clog2(c_STRB_W) : 0;
    localparam int c_IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int c_IDXF_W = ADDR_WIDTH - c_LSB;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_setup;
    logic                  w_complete;
    logic                  w_cnt_dec;
    logic                  w_commit;
    logic                  w_ready;

    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [c_IDX_W-1:0]    r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_STRB_W-1:0]   r_strb;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [NUM_REGS-1:0]   r_wrpulse;

    logic [c_IDXF_W-1:0]   w_idx_full;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_misaligned;
    logic                  w_in_range;
    logic                  w_err_now;
    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

    // Address decode for the setup phase
    assign w_idx_full = PADDR[ADDR_WIDTH-1:c_LSB];
    assign w_idx      = w_idx_full[c_IDX_W-1:0];
    assign w_in_range = (32'(w_idx_full) < NUM_REGS);

    generate
        if (c_LSB > 0) begin : g_align
            assign w_misaligned = |PADDR[c_LSB-1:0];
        end else begin : g_noalign
            assign w_misaligned = 1'b0;
        end
    endgenerate

    assign w_err_now = w_misaligned || !w_in_range || (PWRITE && RO_MASK[w_idx]);

    always_ff @(posedge PCLK) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_setup     = 1'b0;
        w_complete  = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_setup     = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!PSEL) begin
                    w_state_nxt = S_IDLE;
                end else if (PENABLE) begin
                    if (r_cnt == 4'd0) begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_commit = w_complete && r_write && !r_err;

    always_ff @(posedge PCLK) begin
        if (reset) begin
            r_cnt     <= 4'd0;
            r_write   <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_wrpulse <= '0;
        end else begin
            r_wrpulse <= '0;
            if (w_commit) begin
                r_wrpulse[r_idx] <= 1'b1;
            end
            if (w_setup) begin
                r_cnt   <= 4'(WAIT_STATES);
                r_write <= PWRITE;
                r_idx   <= w_idx;
                r_wdata <= PWDATA;
                r_strb  <= PSTRB;
                r_err   <= w_err_now;
                r_rdata <= w_err_now ? '0 : w_regs[w_idx];
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (RO_MASK[gi]) begin : g_ro
                assign w_regs[gi]                            = HwIn[gi*DATA_WIDTH +: DATA_WIDTH];
                assign RegOut[gi*DATA_WIDTH +: DATA_WIDTH]   = '0;
            end else begin : g_rw
                logic [DATA_WIDTH-1:0] r_val;
                logic                  w_unused_hw;

                // Status input is only meaningful for read-only slots
                assign w_unused_hw = ^HwIn[gi*DATA_WIDTH +: DATA_WIDTH];

                always_ff @(posedge PCLK) begin
                    if (reset) begin
                        r_val <= RESET_VAL;
                    end else if (w_commit && (r_idx == c_IDX_W'(gi))) begin
                        for (int b = 0; b < c_STRB_W; b++) begin
                            if (r_strb[b]) begin
                                r_val[b*8 +: 8] <= r_wdata[b*8 +: 8];
                            end
                        end
                    end
                end

                assign w_regs[gi]                          = r_val;
                assign RegOut[gi*DATA_WIDTH +: DATA_WIDTH] = r_val;
            end
        end
    endgenerate

    // Response is decoded from registered state only
    assign w_ready = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign PREADY  = w_ready;
    assign PSLVERR = w_ready && r_err;
    assign PRDATA  = (w_ready && !r_write) ? r_rdata : '0;
    assign WrPulse = r_wrpulse;

endmodule

`default_nettype wire
